// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg -- shared definitions for the Tetris playfield.
//
// Contents:
//   ROWS_DEFAULT / COLS_DEFAULT : default playfield size in cells
//   LINES_MAX                   : saturation value of the cleared-line counter
//   state_t                     : board FSM states (IDLE, SCAN)
//   lock_hit()                  : true when a cell index lies under a 2-wide
//                                 piece footprint starting at 'anchor'
// -----------------------------------------------------------------------------
package tetris_pkg;

   localparam int ROWS_DEFAULT = 20;
   localparam int COLS_DEFAULT = 10;
   localparam int LINES_MAX    = 255;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // The piece is a 2x2 square, so along either axis it covers anchor and
   // anchor+1. Cells past the board edge are never asked about, which is what
   // makes clipping free in the caller.
   function automatic logic lock_hit(input int idx, input int anchor);
      return (idx == anchor) || (idx == anchor + 1);
   endfunction

endpackage : tetris_pkg

// File: rtl/tetris_row_full.sv
// -----------------------------------------------------------------------------
// tetris_row_full -- reports whether one playfield row is completely occupied.
//
// Ports:
//   row  [COLS-1:0] in  : occupancy bits of the row under test
//   full            out : 1 when every cell of the row is occupied
// -----------------------------------------------------------------------------
module tetris_row_full
   import tetris_pkg::*;
#(
   parameter int COLS = COLS_DEFAULT
) (
   input  logic [COLS-1:0] row,
   output logic            full
);

   assign full = &row;

endmodule : tetris_row_full

// File: rtl/tetris_board.sv
// -----------------------------------------------------------------------------
// tetris_board -- playfield occupancy store with 2x2 piece locking and
// row-by-row line clearing.
//
// Ports:
//   frame_clk                  in  : clock, all state changes on rising edge
//   Reset                      in  : asynchronous active-high reset
//   stuck                      in  : lock request from the piece controller
//   BallGridX [3:0]            in  : piece anchor column (top-left cell)
//   BallGridY [4:0]            in  : piece anchor row (row 0 = top)
//   grid [ROWS-1:0][COLS-1:0]  out : occupancy, grid[row][col], 1 = occupied
//   busy                       out : board is not IDLE
//   lines_cleared [7:0]        out : total rows removed, saturates at 255
//   game_over                  out : sticky stack-overflow flag
//
// Configuration:
//   TETRIS_LINE_CLEAR_EN  defined   : after a lock the board scans bottom-up,
//                                     removing full rows (busy ROWS + F cycles).
//                         undefined : a lock returns to IDLE on the next edge,
//                                     rows are never removed, lines_cleared = 0.
// -----------------------------------------------------------------------------
module tetris_board
   import tetris_pkg::*;
#(
   parameter int ROWS = ROWS_DEFAULT,
   parameter int COLS = COLS_DEFAULT
) (
   input  logic                       frame_clk,
   input  logic                       Reset,
   input  logic                       stuck,
   input  logic [3:0]                 BallGridX,
   input  logic [4:0]                 BallGridY,
   output logic [ROWS-1:0][COLS-1:0]  grid,
   output logic                       busy,
   output logic [7:0]                 lines_cleared,
   output logic                       game_over
);

   state_t                      state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]   grid_q, grid_d;
   logic                        game_over_q, game_over_d;

`ifdef TETRIS_LINE_CLEAR_EN
   localparam int             RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0]  R_TOP = RW'(ROWS - 1);

   logic [RW-1:0]  r_q, r_d;
   logic [7:0]     lines_q, lines_d;
   logic           row_full;

   tetris_row_full #(
      .COLS (COLS)
   ) u_row_full (
      .row  (grid_q[r_q]),
      .full (row_full)
   );
`endif

   always_comb begin
      // NOTE: every signal assigned here gets its hold value first; a path
      // that skipped an assignment would otherwise infer a latch.
      state_d     = state_q;
      grid_d      = grid_q;
      game_over_d = game_over_q;
`ifdef TETRIS_LINE_CLEAR_EN
      r_d         = r_q;
      lines_d     = lines_q;
`endif

      case (state_q)
         IDLE: begin
            if (stuck && !game_over_q) begin
               // Walk only in-bounds cells, so footprint cells past the right
               // or bottom edge are simply never written.
               for (int r = 0; r < ROWS; r++) begin
                  for (int c = 0; c < COLS; c++) begin
                     if (lock_hit(r, int'(BallGridY)) && lock_hit(c, int'(BallGridX))) begin
                        if (grid_q[r][c]) begin
                           game_over_d = 1'b1;
                        end
                        grid_d[r][c] = 1'b1;
                     end
                  end
               end
               // A piece locking on the top row means the stack reached it.
               if (BallGridY == '0) begin
                  game_over_d = 1'b1;
               end
`ifdef TETRIS_LINE_CLEAR_EN
               r_d = R_TOP;
`endif
               state_d = SCAN;
            end
         end

         SCAN: begin
`ifdef TETRIS_LINE_CLEAR_EN
            if (row_full) begin
               // Drop everything above r by one row; r stays put so the row
               // that just fell into place is tested on the next edge.
               for (int k = 1; k < ROWS; k++) begin
                  if (k <= int'(r_q)) begin
                     grid_d[k] = grid_q[k-1];
                  end
               end
               grid_d[0] = '0;
               if (lines_q != 8'(LINES_MAX)) begin
                  lines_d = lines_q + 8'd1;
               end
            end else if (r_q == '0) begin
               state_d = IDLE;
            end else begin
               r_d = r_q - RW'(1);
            end
`else
            state_d = IDLE;
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: the grid is a flop array visible on the ports, so it is
         // reset like any other state rather than left as uninitialised memory.
         grid_q      <= '0;
         state_q     <= IDLE;
         game_over_q <= 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
         r_q         <= R_TOP;
         lines_q     <= '0;
`endif
      end else begin
         grid_q      <= grid_d;
         state_q     <= state_d;
         game_over_q <= game_over_d;
`ifdef TETRIS_LINE_CLEAR_EN
         r_q         <= r_d;
         lines_q     <= lines_d;
`endif
      end
   end

   assign grid      = grid_q;
   assign busy      = (state_q != IDLE);
   assign game_over = game_over_q;
`ifdef TETRIS_LINE_CLEAR_EN
   assign lines_cleared = lines_q;
`else
   assign lines_cleared = 8'd0;
`endif

endmodule : tetris_board

// File: tb/tb_tetris_board.sv
// -----------------------------------------------------------------------------
// tb_tetris_board -- self-checking bench for tetris_board.
// Directed vector table, hand-written corner sequences and randomized locks,
// all checked against a cell-array reference model of the playfield.
// Honours TETRIS_LINE_CLEAR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_tetris_board;

   localparam int ROWS       = 20;
   localparam int COLS       = 10;
   localparam int BUSY_LIMIT = 200;
`ifdef TETRIS_LINE_CLEAR_EN
   localparam bit LC_EN = 1'b1;
`else
   localparam bit LC_EN = 1'b0;
`endif
   localparam int B_LOCK = LC_EN ? ROWS : 1;

   logic                      frame_clk;
   logic                      Reset;
   logic                      stuck;
   logic [3:0]                BallGridX;
   logic [4:0]                BallGridY;
   logic [ROWS-1:0][COLS-1:0] grid;
   logic                      busy;
   logic [7:0]                lines_cleared;
   logic                      game_over;

   tetris_board #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .stuck         (stuck),
      .BallGridX     (BallGridX),
      .BallGridY     (BallGridY),
      .grid          (grid),
      .busy          (busy),
      .lines_cleared (lines_cleared),
      .game_over     (game_over)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: plain cell array plus counters.
   bit m_grid [ROWS][COLS];
   int m_lines;
   bit m_go;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_grid(input string name);
      logic [ROWS-1:0][COLS-1:0] exp;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp[r][c] = m_grid[r][c];
      n_checks++;
      if (grid !== exp) begin
         n_fails++;
         $display("FAIL %s: grid got %h, expected %h", name, grid, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m_grid[r][c] = 1'b0;
      m_lines = 0;
      m_go    = 1'b0;
   endtask

   // Place the square, then (with line clear) drop every full row at once:
   // the board ends up with the non-full rows stacked at the bottom in order.
   task automatic model_lock(input int x, input int y, output int exp_busy);
      bit tmp [ROWS][COLS];
      int dst;
      int f;
      bit full;
      if (m_go) begin
         exp_busy = 0;
         return;
      end
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++)
            if (y + dy < ROWS && x + dx < COLS) begin
               if (m_grid[y+dy][x+dx]) m_go = 1'b1;
               m_grid[y+dy][x+dx] = 1'b1;
            end
      if (y == 0) m_go = 1'b1;
      if (!LC_EN) begin
         exp_busy = 1;
         return;
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            tmp[r][c] = 1'b0;
      dst = ROWS - 1;
      f   = 0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++) full &= m_grid[r][c];
         if (full) f++;
         else begin
            for (int c = 0; c < COLS; c++) tmp[dst][c] = m_grid[r][c];
            dst--;
         end
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m_grid[r][c] = tmp[r][c];
      m_lines  = (m_lines + f > 255) ? 255 : m_lines + f;
      exp_busy = ROWS + f;
   endtask

   // Entered and left just after a falling edge.
   task automatic apply_reset();
      Reset = 1'b1;
      stuck = 1'b0;
      repeat (2) @(negedge frame_clk);
      Reset = 1'b0;
      model_reset();
      @(negedge frame_clk);
   endtask

   task automatic dut_lock(input int x, input int y, output int cnt);
      BallGridX = x[3:0];
      BallGridY = y[4:0];
      stuck     = 1'b1;
      @(negedge frame_clk);
      stuck = 1'b0;
      cnt   = 0;
      while (busy && cnt < BUSY_LIMIT) begin
         cnt++;
         @(negedge frame_clk);
      end
   endtask

   task automatic do_lock(input int x, input int y);
      int eb;
      int cnt;
      model_lock(x, y, eb);
      dut_lock(x, y, cnt);
      check("busy_cycles", cnt, eb);
      check("lines_cleared", lines_cleared, m_lines);
      check("game_over", game_over, m_go);
      check_grid("grid_after_lock");
   endtask

   typedef struct {
      bit rst;
      int x;
      int y;
      int exp_busy;
      int exp_lines;
      bit exp_go;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int eb;
      int cnt;
      int extra;
      int x;
      int y;

      vecs[0]  = '{1'b1, 4, 18, B_LOCK,                0,                 1'b0};
      vecs[1]  = '{1'b1, 0, 18, B_LOCK,                0,                 1'b0};
      vecs[2]  = '{1'b0, 2, 18, B_LOCK,                0,                 1'b0};
      vecs[3]  = '{1'b0, 4, 18, B_LOCK,                0,                 1'b0};
      vecs[4]  = '{1'b0, 6, 18, B_LOCK,                0,                 1'b0};
      vecs[5]  = '{1'b0, 8, 18, LC_EN ? ROWS + 2 : 1,  LC_EN ? 2 : 0,     1'b0};
      vecs[6]  = '{1'b1, 4, 18, B_LOCK,                0,                 1'b0};
      vecs[7]  = '{1'b0, 4, 18, B_LOCK,                0,                 1'b1};
      vecs[8]  = '{1'b0, 4, 18, 0,                     0,                 1'b1};
      vecs[9]  = '{1'b1, 9, 5,  B_LOCK,                0,                 1'b0};
      vecs[10] = '{1'b1, 0, 0,  B_LOCK,                0,                 1'b1};
      // vecs[10] reuses the board of vecs[9] in spirit; force no reset there.
      vecs[10].rst = 1'b0;

      Reset     = 1'b1;
      stuck     = 1'b0;
      BallGridX = '0;
      BallGridY = '0;
      model_reset();
      @(negedge frame_clk);
      apply_reset();
      check("reset_busy", busy, 0);
      check("reset_lines", lines_cleared, 0);
      check("reset_game_over", game_over, 0);
      check_grid("reset_grid");

      // Directed vectors.
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].rst) apply_reset();
         model_lock(vecs[i].x, vecs[i].y, eb);
         dut_lock(vecs[i].x, vecs[i].y, cnt);
         check("vec_busy", cnt, vecs[i].exp_busy);
         check("vec_lines", lines_cleared, vecs[i].exp_lines);
         check("vec_game_over", game_over, vecs[i].exp_go);
         check_grid("vec_grid");
      end

      // stuck held into the busy period with a new anchor: must be ignored.
      apply_reset();
      model_lock(0, 18, eb);
      BallGridX = 4'd0;
      BallGridY = 5'd18;
      stuck     = 1'b1;
      @(negedge frame_clk);
      cnt = busy ? 1 : 0;
      BallGridY = 5'd10;
      @(negedge frame_clk);
      stuck = 1'b0;
      while (busy && cnt < BUSY_LIMIT) begin
         cnt++;
         @(negedge frame_clk);
      end
      check("busy_pulse_cycles", cnt, eb);
      check_grid("busy_pulse_grid");
      extra = 0;
      repeat (5) begin
         if (busy) extra++;
         @(negedge frame_clk);
      end
      check("busy_pulse_no_extra", extra, 0);

      // Reset on the third SCAN cycle of the two-row clear.
      apply_reset();
      for (int i = 0; i < 4; i++) do_lock(2 * i, 18);
      BallGridX = 4'd8;
      BallGridY = 5'd18;
      stuck     = 1'b1;
      @(negedge frame_clk);
      stuck = 1'b0;
      repeat (2) @(negedge frame_clk);
      Reset = 1'b1;
      @(negedge frame_clk);
      Reset = 1'b0;
      model_reset();
      @(negedge frame_clk);
      check("midscan_busy", busy, 0);
      check("midscan_lines", lines_cleared, 0);
      check("midscan_game_over", game_over, 0);
      check_grid("midscan_grid");
      extra = 0;
      repeat (3) begin
         if (busy || grid != '0) extra++;
         @(negedge frame_clk);
      end
      check("midscan_quiet", extra, 0);

      // Randomized locks, biased toward the bottom rows so clears happen.
      apply_reset();
      for (int i = 0; i < 150; i++) begin
         if (m_go) apply_reset();
         if ($urandom_range(0, 3) != 0) begin
            x = 2 * $urandom_range(0, 4);
            y = $urandom_range(14, 18);
         end else begin
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 31);
         end
         do_lock(x, y);
      end

      // Fill the bottom two rows repeatedly to drive the counter past 255.
      apply_reset();
      for (int round = 0; round < 128; round++)
         for (int i = 0; i < 5; i++)
            do_lock(2 * i, 18);
      check("saturated_lines", lines_cleared, LC_EN ? 255 : 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_tetris_board
